// File: rtl/mem_access_unit_if.sv
// Bundles the request/response handshake and the memory bus of mem_access_unit.
// master = control FSM plus memory model side, slave = the access unit itself.
interface mem_access_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [ADDR_W-1:0]   req_addr;
    logic [XLEN-1:0]     req_wdata;
    logic [1:0]          req_size;
    logic                req_unsigned;
    logic                rsp_valid;
    logic [XLEN-1:0]     rsp_rdata;
    logic                rsp_error;
    logic                mem_valid;
    logic                mem_ready;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [XLEN/8-1:0]   mem_wstrb;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN-1:0]     mem_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store port between the multicycle control FSM and shared memory:
// valid/ready handshake, sub-word accesses, misalignment and wait-state timeout.
module mem_access_unit #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);
    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [STRB_W-1:0] mem_wstrb_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic [XLEN-1:0]   rsp_rdata_q;
    logic              rsp_error_q;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [31:0]       wait_cnt;

    logic              accept;
    logic              misaligned;
    logic              illegal_size;
    logic              timed_out;
    logic [OFF_W-1:0]  req_off;
    logic [STRB_W-1:0] req_strb;
    logic [XLEN-1:0]   req_wrep;
    logic [XLEN-1:0]   rd_shift;
    logic [XLEN-1:0]   keep_mask;
    logic              sign_bit;
    logic [XLEN-1:0]   load_ext;

    assign bus.req_ready = (state == ST_IDLE) && reset;
    assign bus.mem_valid = (state == ST_ACCESS);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;

    assign accept       = bus.req_valid && bus.req_ready;
    assign req_off      = bus.req_addr[OFF_W-1:0];
    assign illegal_size = (bus.req_size == 2'd3) && (XLEN == 32);
    assign timed_out    = (TIMEOUT > 0) && ((wait_cnt + 32'd1) == 32'(TIMEOUT));

    always_comb begin
        misaligned = 1'b0;
        case (bus.req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = bus.req_addr[0];
            2'd2:    misaligned = |bus.req_addr[1:0];
            default: misaligned = |bus.req_addr[2:0];
        endcase
    end

    // Store lanes: strobes select the addressed bytes, data is replicated so any lane sees it.
    always_comb begin
        req_strb = '1;
        req_wrep = bus.req_wdata;
        case (bus.req_size)
            2'd0: begin
                req_strb = STRB_W'(1) << req_off;
                req_wrep = {STRB_W{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                req_strb = STRB_W'(3) << req_off;
                req_wrep = {(STRB_W / 2){bus.req_wdata[15:0]}};
            end
            2'd2: begin
                req_strb = STRB_W'(15) << req_off;
                req_wrep = {(STRB_W / 4){bus.req_wdata[31:0]}};
            end
            default: begin
                req_strb = '1;
                req_wrep = bus.req_wdata;
            end
        endcase
    end

    // Load path: bring the addressed bytes down to bit 0, then extend via a keep mask.
    always_comb begin
        rd_shift  = bus.mem_rdata >> {off_q, 3'b000};
        keep_mask = '1;
        sign_bit  = rd_shift[XLEN-1];
        case (size_q)
            2'd0: begin
                keep_mask = XLEN'(8'hFF);
                sign_bit  = rd_shift[7];
            end
            2'd1: begin
                keep_mask = XLEN'(16'hFFFF);
                sign_bit  = rd_shift[15];
            end
            2'd2: begin
                keep_mask = XLEN'(32'hFFFF_FFFF);
                sign_bit  = rd_shift[31];
            end
            default: begin
                keep_mask = '1;
                sign_bit  = rd_shift[XLEN-1];
            end
        endcase
        load_ext = (rd_shift & keep_mask) |
                   (~keep_mask & {XLEN{sign_bit & ~unsigned_q}});
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            off_q       <= '0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        off_q       <= req_off;
                        size_q      <= bus.req_size;
                        unsigned_q  <= bus.req_unsigned;
                        wait_cnt    <= '0;
                        mem_addr_q  <= {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        mem_we_q    <= bus.req_write;
                        mem_wstrb_q <= bus.req_write ? req_strb : '0;
                        mem_wdata_q <= bus.req_write ? req_wrep : '0;
                        if (misaligned || illegal_size) begin
                            rsp_error_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            state       <= ST_RESP;
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                // A handshake in the same cycle the counter expires takes priority.
                ST_ACCESS: begin
                    if (bus.mem_ready) begin
                        rsp_error_q <= 1'b0;
                        rsp_rdata_q <= mem_we_q ? '0 : load_ext;
                        state       <= ST_RESP;
                    end else if (timed_out) begin
                        rsp_error_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        state       <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised load/store port between the multicycle control FSM/datapath and the shared instruction/data memory.
- Replaces the fixed single-cycle, word-only, write-disabled memory hookup.
- Adds a valid/ready handshake to variable-latency memory, plus byte/halfword/word(/doubleword) accesses with byte strobes and sign/zero extension.
- Adds misalignment detection and an optional wait-state timeout.

Parameters:
XLEN, 32, data width; legal values 32 or 64
ADDR_W, 32, byte-address width
TIMEOUT, 0, max cycles waiting for mem_ready before abort; 0 disables timeout

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  1  access request from control FSM
req_ready  out  1  unit idle and able to accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, right-aligned
req_size  in  2  00 byte, 01 half, 10 word, 11 double (XLEN=64 only)
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  XLEN  extended load data (0 for stores/errors)
rsp_error  out  1  qualifies rsp_valid: misaligned, illegal size or timeout
mem_valid  out  1  memory request
mem_ready  in  1  memory accepts/completes request this cycle
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  XLEN/8-aligned address (low bits zero)
mem_wstrb  out  XLEN/8  byte write strobes
mem_wdata  out  XLEN  lane-replicated store data
mem_rdata  in  XLEN  read data, valid when mem_valid && mem_ready && !mem_we

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- reset low at an edge: state <= IDLE. All outputs are 0 while reset is low, including req_ready (forced 0). This applies mid-ACCESS too: mem_valid drops at the reset edge, and no response is issued for the aborted request.
- req_ready = (state == IDLE) && reset.
- IDLE: on req_valid && req_ready, latch the request (addr, size, write, unsigned, wdata).
  - Misaligned (addr not a multiple of 2^size) or illegal size (11 with XLEN=32): go to RESP with error=1 and no memory access.
  - Otherwise: go to ACCESS.
- ACCESS: mem_valid=1 from the cycle after acceptance. mem_addr, mem_we, mem_wstrb and mem_wdata are registered and stable until the handshake.
  - On mem_valid && mem_ready: capture the extended read data (loads) and go to RESP with error=0.
  - Handshake latency 0..N cycles.
- Timeout: the wait counter resets on entry to ACCESS and increments each ACCESS cycle without mem_ready.
  - If TIMEOUT>0 and the counter reaches TIMEOUT, go to RESP with error=1 and rdata=0; mem_valid deasserts.
  - If mem_ready arrives in the same cycle the counter reaches TIMEOUT, the handshake wins.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata/rsp_error are held until the next response; they are only meaningful with rsp_valid.
- Minimum latency:
  - Aligned access: acceptance edge N, mem_valid during cycle N+1; with mem_ready then, rsp_valid during cycle N+2.
  - Error: rsp_valid during cycle N+1.
- Byte offset off = addr[log2(XLEN/8)-1:0].
- Store strobes:
  - byte: 1<<off
  - half: 2'b11<<off
  - word: 4'hF<<off
  - double: all ones
- Store data: the low 2^size bytes of req_wdata are replicated across all lanes.
- Load: shift mem_rdata right by 8*off, take the low 2^size bytes, then sign- or zero-extend to XLEN. Word/double at full width is passed through unextended.
- Loads drive mem_wstrb=0 and mem_wdata=0.
- No back-to-back acceptance: req_ready is low in ACCESS and RESP. A request presented then is not consumed and must be held by the requester.

Test Plan:
- XLEN=32, mem_ready tied 1, load word addr 0x100, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0, rsp_valid two cycles after acceptance, rsp_rdata=0xDEADBEEF, rsp_error=0.
- Signed byte load addr 0x103, mem_rdata=0x80112233 -> rsp_rdata=0xFFFFFF80; same with req_unsigned=1 -> 0x00000080.
- Halfword store addr 0x206, wdata=0x0000ABCD, mem_ready after 3 wait cycles -> mem_addr=0x204, mem_wstrb=4'b1100, mem_wdata=0xABCDABCD stable for all 4 mem_valid cycles; one rsp_valid pulse with rsp_error=0.
- Word load addr 0x102 -> mem_valid never asserted, rsp_valid one cycle after acceptance with rsp_error=1; size=11 at XLEN=32 -> same.
- TIMEOUT=4, mem_ready held 0 -> mem_valid high exactly 4 cycles, then rsp_valid with rsp_error=1, rsp_rdata=0, req_ready high next cycle.
- reset driven low during ACCESS -> mem_valid=0 and req_ready=0 after that edge, no rsp_valid; after release a fresh word load completes normally.
